// File: rtl/alu_issue_seq.sv
// Issue sequencer for the ALUController: accepts one instruction, reads its operands
// from the register file, drives the ALU and writes the result back. Optional macro: ALU_IMM_EN.
module alu_issue_seq #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic              in_iscmp,
  input  logic [REG_AW-1:0] in_dst,
  input  logic [REG_AW-1:0] in_srca,
  input  logic [REG_AW-1:0] in_srcb,
  input  logic              in_imm_sel,
  input  logic [DATA_W-1:0] in_imm,
  output logic [REG_AW-1:0] rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [DATA_W-1:0] alu_d0,
  output logic [DATA_W-1:0] alu_d1,
  output logic [3:0]        alu_op,
  output logic              alu_iscmp,
  input  logic [DATA_W-1:0] alu_dout,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RDA  = 3'd1,
    RDB  = 3'd2,
    EXB  = 3'd3,
    WB   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [REG_AW-1:0]   dst_q;
  logic [REG_AW-1:0]   srcb_q;
  logic [REG_AW-1:0]   raddr_q, raddr_d;
  logic [REG_AW-1:0]   waddr_q, waddr_d;
  logic [DATA_W-1:0]   d0_q, d1_q, d1_src;
  logic [3:0]          op_q;
  logic                iscmp_q;
  logic                we_q, we_d;
  logic                ready_q, ready_d;
  logic                accept, load_d0, load_d1;
  logic                imm_path;

`ifdef ALU_IMM_EN
  logic [DATA_W-1:0]   imm_q;
  logic                imm_sel_q;

  assign imm_path = imm_sel_q;
  assign d1_src   = (imm_path && (state_q == RDB)) ? imm_q : rf_rdata;
`else
  logic                unused_imm;

  assign imm_path   = 1'b0;
  assign d1_src     = rf_rdata;
  assign unused_imm = ^{in_imm_sel, in_imm};
`endif

  // Next state, read-address schedule and operand load strobes
  always_comb begin
    state_d = state_q;
    raddr_d = '0;
    waddr_d = '0;
    accept  = 1'b0;
    load_d0 = 1'b0;
    load_d1 = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          accept  = 1'b1;
          raddr_d = in_srca;
          state_d = RDA;
        end
      end
      RDA: begin
        raddr_d = srcb_q;
        state_d = RDB;
      end
      RDB: begin
        load_d0 = 1'b1;
        if (imm_path) begin
          load_d1 = 1'b1;
          state_d = WB;
        end else begin
          state_d = EXB;
        end
      end
      EXB: begin
        load_d1 = 1'b1;
        state_d = WB;
      end
      WB: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    we_d    = (state_d == WB);
    ready_d = (state_d == IDLE);
    if (state_d == WB) begin
      waddr_d = dst_q;
    end
  end

  // State, latched instruction fields and ALU operand registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      dst_q     <= '0;
      srcb_q    <= '0;
      raddr_q   <= '0;
      waddr_q   <= '0;
      d0_q      <= '0;
      d1_q      <= '0;
      op_q      <= '0;
      iscmp_q   <= 1'b0;
      we_q      <= 1'b0;
      ready_q   <= 1'b1;
`ifdef ALU_IMM_EN
      imm_q     <= '0;
      imm_sel_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      raddr_q <= raddr_d;
      waddr_q <= waddr_d;
      we_q    <= we_d;
      ready_q <= ready_d;
      if (accept) begin
        dst_q     <= in_dst;
        srcb_q    <= in_srcb;
        op_q      <= in_op;
        iscmp_q   <= in_iscmp;
`ifdef ALU_IMM_EN
        imm_q     <= in_imm;
        imm_sel_q <= in_imm_sel;
`endif
      end
      if (load_d0) begin
        d0_q <= rf_rdata;
      end
      if (load_d1) begin
        d1_q <= d1_src;
      end
    end
  end

  // A reset sampled on the WB edge must also block that cycle's write
  assign rf_we     = we_q & ~reset;
  assign done      = we_q & ~reset;
  assign rf_waddr  = waddr_q;
  assign rf_wdata  = alu_dout;
  assign rf_raddr  = raddr_q;
  assign in_ready  = ready_q;
  assign alu_d0    = d0_q;
  assign alu_d1    = d1_q;
  assign alu_op    = op_q;
  assign alu_iscmp = iscmp_q;

endmodule
